vedic_mul_arbiter: RTL and testbench

//  Shares one signed NxN combinational Anurupyena Vedic multiplier among NREQ

---
 rtl/vedic_mul_arbiter.sv | 106 ++++++++++
 tb/tb_vedic_mul_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mul_arbiter.sv
// Round-robin front end that time-shares one external combinational signed
// multiplier among NREQ requesters, holding operands for MUL_LAT cycles.
module vedic_mul_arbiter #(
   parameter int N       = 8,
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 1,
   parameter int IDW     = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*N-1:0]   req_x,
   input  logic [NREQ*N-1:0]   req_y,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [2*N-1:0]      rsp_result,
   output logic [N-1:0]        mul_x,
   output logic [N-1:0]        mul_y,
   input  logic [2*N-1:0]      mul_result,
   output logic                busy
);

   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [IDW-1:0]  last_grant;
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  cand;
   logic            found;

   // Search starts one past the previous winner so every requester is served in turn.
   // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last_grant) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found)       state_nxt = MUL;
         MUL:     if (cnt == '0)   state_nxt = RESP;
         RESP:    if (rsp_ready)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // Grant is gated by rst_n so no requester sees an accept while reset is held.
   always_comb begin
      req_ready = '0;
      busy      = (state != IDLE);
      if (state == IDLE && found && rst_n) req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= IDW'(NREQ - 1);
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         mul_x      <= '0;
         mul_y      <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               mul_x      <= req_x[int'(winner)*N +: N];
               mul_y      <= req_y[int'(winner)*N +: N];
               rsp_id     <= winner;
               last_grant <= winner;
               cnt        <= CW'(MUL_LAT - 1);
            end
            MUL: begin
               if (cnt == '0) begin
                  rsp_result <= mul_result;
                  rsp_valid  <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: if (rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Directed bench for vedic_mul_arbiter: a behavioural multiplier stands in for
// the Vedic array, and a scoreboard queue matches each grant to its response.
module tb_vedic_mul_arbiter;

   localparam int N = 8, NREQ = 4, MUL_LAT = 1, IDW = 2;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*N-1:0]   req_x, req_y;
   logic                rsp_valid, rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [2*N-1:0]      rsp_result;
   logic [N-1:0]        mul_x, mul_y;
   logic [2*N-1:0]      mul_result;
   logic                busy;

   logic signed [2*N-1:0] sx, sy;
   assign sx = {{N{mul_x[N-1]}}, mul_x};
   assign sy = {{N{mul_y[N-1]}}, mul_y};
   assign mul_result = sx * sy;

   vedic_mul_arbiter #(.N(N), .NREQ(NREQ), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .mul_x(mul_x), .mul_y(mul_y),
      .mul_result(mul_result), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [15:0] res;
      logic [7:0]  x;
      logic [7:0]  y;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
      req_x[i*N +: N] = x;
      req_y[i*N +: N] = y;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_grant(input int exp_id, input logic [15:0] exp_res, input bit push);
      bit got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            got = 1'b1;
            check("grant", 32'(req_ready), 32'(1 << exp_id));
            if (push) sb.push_back('{id: exp_id, res: exp_res,
                                     x: req_x[exp_id*N +: N], y: req_y[exp_id*N +: N]});
         end
      end
      check("grant_timeout", 32'(got), 32'd1);
   endtask

   task automatic wait_rsp(input int exp_lat);
      int   n   = 0;
      bit   got = 1'b0;
      exp_t e;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (rsp_valid) got = 1'b1;
      end
      check("rsp_timeout", 32'(got), 32'd1);
      if (got) begin
         check("latency", 32'(n), 32'(exp_lat));
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_result", 32'(rsp_result), 32'(e.res));
            check("mul_x_held", 32'(mul_x), 32'(e.x));
            check("mul_y_held", 32'(mul_y), 32'(e.y));
         end
      end
   endtask

   // Invariants: at most one grant, and never a grant while busy.
   always @(negedge clk) if (rst_n === 1'b1) begin
      check("onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("ready_when_busy", 32'(busy && (|req_ready)), 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [7:0]  cx[4] = '{8'h80, 8'h80, 8'h7F, 8'h00};
   logic [7:0]  cy[4] = '{8'h80, 8'h7F, 8'hFF, 8'h01};
   logic [15:0] ce[4] = '{16'h4000, 16'hC080, 16'hFF81, 16'h0000};
   logic [15:0] e2[4] = '{16'h0078, 16'hFF10, 16'h0001, 16'h0001};

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      req_x     = '0;
      req_y     = '0;
      #12;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_result", 32'(rsp_result), 32'd0);
      check("rst_mul_x", 32'(mul_x), 32'd0);
      check("rst_mul_y", 32'(mul_y), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      req_valid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single request.
      set_op(0, 8'h1B, 8'h05);
      req_valid = 4'b0001;
      wait_grant(0, 16'h0087, 1'b1);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(MUL_LAT + 1);

      // All four requesting from a fresh reset: grants 0,1,2,3.
      do_reset();
      set_op(0, 8'd12, 8'd10);
      set_op(1, 8'hF0, 8'd15);
      set_op(2, 8'd1, 8'd1);
      set_op(3, 8'hFF, 8'hFF);
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_grant(i, e2[i], 1'b1);
         wait_rsp(MUL_LAT + 1);
      end
      req_valid = '0;

      // Fairness between requesters 1 and 3.
      set_op(1, 8'd7, 8'd9);
      set_op(3, 8'hFB, 8'd3);
      req_valid = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) wait_grant(1, 16'h003F, 1'b1);
         else            wait_grant(3, 16'hFFF1, 1'b1);
         wait_rsp(MUL_LAT + 1);
      end
      req_valid = '0;

      // Backpressure: response held for five cycles, others kept waiting.
      set_op(0, 8'd3, 8'hFE);
      req_valid = 4'b0001;
      wait_grant(0, 16'hFFFA, 1'b1);
      @(posedge clk);
      #1 begin
         req_valid = 4'b0110;
         rsp_ready = 1'b0;
      end
      wait_rsp(MUL_LAT + 1);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check("bp_valid", 32'(rsp_valid), 32'd1);
         check("bp_id", 32'(rsp_id), 32'd0);
         check("bp_result", 32'(rsp_result), 32'hFFFA);
         check("bp_no_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_done", 32'(rsp_valid), 32'd0);
      check("bp_next_grant", 32'(req_ready), 32'b0010);
      req_valid = '0;

      // Arithmetic corners through requester 2.
      for (int i = 0; i < 4; i++) begin
         set_op(2, cx[i], cy[i]);
         req_valid = 4'b0100;
         wait_grant(2, ce[i], 1'b1);
         @(posedge clk);
         #1 req_valid = '0;
         wait_rsp(MUL_LAT + 1);
      end

      // Reset during MUL discards the operation and restarts from requester 0.
      set_op(0, 8'h11, 8'h02);
      req_valid = 4'b0001;
      wait_grant(0, 16'h0022, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 begin
         set_op(0, 8'd6, 8'd7);
         req_valid = 4'b1111;
         rst_n     = 1'b1;
      end
      wait_grant(0, 16'h002A, 1'b1);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(MUL_LAT + 1);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
